// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a word-at-a-time line refill.
// Hits answer combinationally; a miss stalls the fetch until the whole line is loaded.
module instr_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Flush,
  output logic [31:0] Instr,
  output logic        Cache_Stall,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_RData,
  input  logic        Mem_Valid
);

  localparam int O = $clog2(WORDS);
  localparam int I = $clog2(LINES);
  localparam int T = 32 - O - I - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t           state_q, state_d;
  logic [O-1:0]     cnt_q, cnt_d;
  logic [T+I-1:0]   base_q, base_d;
  logic             discard_q, discard_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [T-1:0]  tagMem  [LINES];
  logic [31:0]   dataMem [LINES][WORDS];

  logic [O-1:0] pcOffset;
  logic [I-1:0] pcIndex;
  logic [T-1:0] pcTag;
  logic [I-1:0] fillIndex;
  logic         hit, memWrite, lastWord;
  logic         unusedPcBits;

  assign pcOffset     = PC[O+1:2];
  assign pcIndex      = PC[O+I+1:O+2];
  assign pcTag        = PC[31:O+I+2];
  assign unusedPcBits = ^PC[1:0];
  assign fillIndex    = base_q[I-1:0];

  assign hit         = (state_q == IDLE) && valid_q[pcIndex] && (tagMem[pcIndex] == pcTag);
  assign Instr       = hit ? dataMem[pcIndex][pcOffset] : 32'h0;
  assign Cache_Stall = !hit;
  assign Mem_Req     = (state_q == REFILL);
  assign Mem_Addr    = Mem_Req ? {base_q, cnt_q, 2'b00} : 32'h0;
  assign memWrite    = Mem_Req && Mem_Valid;
  // WORDS is a power of two, so the last word is the all-ones count.
  assign lastWord    = &cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d          = REFILL;
          cnt_d            = '0;
          base_d           = {pcTag, pcIndex};
          // The victim line is dead as soon as it starts being overwritten.
          valid_d[pcIndex] = 1'b0;
        end
      end
      REFILL: begin
        if (Flush) discard_d = 1'b1;
        if (memWrite) begin
          cnt_d = cnt_q + 1'b1;
          if (lastWord) begin
            state_d   = IDLE;
            discard_d = 1'b0;
            if (!discard_q) valid_d[fillIndex] = 1'b1;
          end
        end
      end
    endcase
    // Flush overrides any valid bit the refill would set this edge.
    if (Flush) valid_d = '0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      discard_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
    end
  end

  // Storage arrays are deliberately left unreset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (memWrite) begin
      dataMem[fillIndex][cnt_q] <= Mem_RData;
      if (lastWord) tagMem[fillIndex] <= base_q[T+I-1:I];
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: a line-level model of valid/tag state plus a
// fixed backing-memory pattern predicts every cycle of hits, refills, flushes and resets.
module tb_instr_cache;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int O = 2;
  localparam int I = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        Flush;
  logic [31:0] Instr;
  logic        Cache_Stall;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_RData;
  logic        Mem_Valid;

  int errors = 0;
  int checks = 0;

  bit          mValid [LINES];
  logic [31:0] mTag   [LINES];

  instr_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .Flush(Flush), .Instr(Instr),
    .Cache_Stall(Cache_Stall), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_RData(Mem_RData), .Mem_Valid(Mem_Valid)
  );

  always #5 CLK = ~CLK;

  // Low memory holds 0xA0 + word number; higher memory gets a scrambled pattern.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a < 32'h1000) return 32'hA0 + (a >> 2);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic void modelFlush();
    for (int l = 0; l < LINES; l++) mValid[l] = 1'b0;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic fl, input logic mv, input logic [31:0] rd);
    PC = pc; Flush = fl; Mem_Valid = mv; Mem_RData = rd;
    @(negedge CLK);
  endtask

  task automatic finishCycle();
    @(posedge CLK);
    #1;
  endtask

  // One fetch at pc, acting as the backing memory, until the model says it hits.
  task automatic fetch(input logic [31:0] pc, input int waits, input int flushCycle,
                       input bit scramble, output int stalls);
    int idx, cyc, fc;
    logic [31:0] tg, base, addr, want, rpc;
    bit discard, flushed, fl;
    stalls = 0;
    fc = flushCycle;
    for (int attempt = 0; attempt < 3; attempt++) begin
      idx = int'((pc >> (O + 2)) % LINES);
      tg  = pc >> (O + I + 2);
      if (mValid[idx] && mTag[idx] == tg) begin
        drive(pc, 1'b0, 1'($urandom), $urandom);
        want = memData(pc & ~32'h3);
        checks += 4;
        if (Cache_Stall !== 1'b0) begin errors++; $display("[TB] FAIL hit_stall pc=%h: got %b want 0", pc, Cache_Stall); end
        if (Instr !== want) begin errors++; $display("[TB] FAIL hit_instr pc=%h: got %h want %h", pc, Instr, want); end
        if (Mem_Req !== 1'b0) begin errors++; $display("[TB] FAIL hit_req pc=%h: got %b want 0", pc, Mem_Req); end
        if (Mem_Addr !== 32'h0) begin errors++; $display("[TB] FAIL hit_addr pc=%h: got %h want 0", pc, Mem_Addr); end
        if (Cache_Stall === 1'b1) stalls++;
        finishCycle();
        return;
      end
      base = pc & ~(WORDS * 4 - 1);
      flushed = (fc == 0);
      discard = 1'b0;
      drive(pc, flushed, 1'($urandom), $urandom);
      checks += 4;
      if (Cache_Stall !== 1'b1) begin errors++; $display("[TB] FAIL detect_stall pc=%h: got %b want 1", pc, Cache_Stall); end
      if (Mem_Req !== 1'b0) begin errors++; $display("[TB] FAIL detect_req pc=%h: got %b want 0", pc, Mem_Req); end
      if (Mem_Addr !== 32'h0) begin errors++; $display("[TB] FAIL detect_addr pc=%h: got %h want 0", pc, Mem_Addr); end
      if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL detect_instr pc=%h: got %h want 0", pc, Instr); end
      if (Cache_Stall === 1'b1) stalls++;
      finishCycle();
      cyc = 1;
      for (int k = 0; k < WORDS; k++) begin
        addr = base + 32'(4 * k);
        for (int w = 0; w <= waits; w++) begin
          rpc = scramble ? $urandom : pc;
          fl = (cyc == fc);
          if (fl) begin flushed = 1'b1; discard = 1'b1; end
          drive(rpc, fl, w == waits, (w == waits) ? memData(addr) : $urandom);
          checks += 4;
          if (Mem_Req !== 1'b1) begin errors++; $display("[TB] FAIL refill_req pc=%h word=%0d: got %b want 1", pc, k, Mem_Req); end
          if (Mem_Addr !== addr) begin errors++; $display("[TB] FAIL refill_addr pc=%h word=%0d: got %h want %h", pc, k, Mem_Addr, addr); end
          if (Cache_Stall !== 1'b1) begin errors++; $display("[TB] FAIL refill_stall pc=%h word=%0d: got %b want 1", pc, k, Cache_Stall); end
          if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL refill_instr pc=%h word=%0d: got %h want 0", pc, k, Instr); end
          if (Cache_Stall === 1'b1) stalls++;
          finishCycle();
          cyc++;
        end
      end
      if (flushed) modelFlush();
      if (!discard) begin mValid[idx] = 1'b1; mTag[idx] = tg; end
      fc = -1;
    end
    checks++; errors++;
    $display("[TB] FAIL fetch_hit pc=%h: got no hit after 3 attempts want hit", pc);
  endtask

  task automatic test_reset();
    Reset = 1'b1; PC = 32'h0; Flush = 1'b0; Mem_Valid = 1'b1; Mem_RData = 32'h0;
    modelFlush();
    @(negedge CLK);
    checks += 4;
    if (Mem_Req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", Mem_Req); end
    if (Mem_Addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", Mem_Addr); end
    if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", Instr); end
    if (Cache_Stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall: got %b want 1", Cache_Stall); end
    finishCycle();
    Reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    int s;
    fetch(32'h0, 0, -1, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL cold_stalls: got %0d want 5", s); end
  endtask

  task automatic test_line_hits();
    int s;
    for (int k = 1; k < WORDS; k++) begin
      fetch(32'(4 * k), 0, -1, 1'b0, s);
      checks++;
      if (s != 0) begin errors++; $display("[TB] FAIL line_hit_stalls word=%0d: got %0d want 0", k, s); end
    end
  endtask

  task automatic test_conflict();
    int s;
    fetch(32'h100, 0, -1, 1'b1, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL conflict_fill_stalls: got %0d want 5", s); end
    fetch(32'h0, 0, -1, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL conflict_evict_stalls: got %0d want 5", s); end
  endtask

  task automatic test_wait_states();
    int s;
    fetch(32'h48, 3, -1, 1'b0, s);
    checks++;
    if (s != 17) begin errors++; $display("[TB] FAIL wait_stalls: got %0d want 17", s); end
  endtask

  task automatic test_flush();
    int s;
    fetch(32'h0, 0, -1, 1'b0, s);
    // Flush is sampled at the coming edge, so this cycle still hits.
    drive(32'h0, 1'b1, 1'b0, 32'h0);
    checks += 2;
    if (Cache_Stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_same_cycle_stall: got %b want 0", Cache_Stall); end
    if (Instr !== 32'hA0) begin errors++; $display("[TB] FAIL flush_same_cycle_instr: got %h want a0", Instr); end
    finishCycle();
    modelFlush();
    fetch(32'h0, 0, -1, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL flush_idle_stalls: got %0d want 5", s); end
    fetch(32'h100, 0, 2, 1'b0, s);
    checks++;
    if (s != 10) begin errors++; $display("[TB] FAIL flush_refill_stalls: got %0d want 10", s); end
    fetch(32'h200, 0, 4, 1'b0, s);
    checks++;
    if (s != 10) begin errors++; $display("[TB] FAIL flush_last_word_stalls: got %0d want 10", s); end
    fetch(32'h300, 0, 0, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL flush_with_miss_stalls: got %0d want 5", s); end
    fetch(32'h48, 0, -1, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL flush_cleared_other_stalls: got %0d want 5", s); end
  endtask

  task automatic test_reset_mid_refill();
    int s;
    fetch(32'h100, 0, -1, 1'b0, s);
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    finishCycle();
    for (int k = 0; k < 2; k++) begin
      drive(32'h0, 1'b0, 1'b1, memData(32'(4 * k)));
      checks++;
      if (Mem_Addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL partial_addr word=%0d: got %h want %h", k, Mem_Addr, 32'(4 * k)); end
      finishCycle();
    end
    Reset = 1'b1;
    #1;
    checks += 3;
    if (Mem_Req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b want 0", Mem_Req); end
    if (Mem_Addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_addr: got %h want 0", Mem_Addr); end
    if (Cache_Stall !== 1'b1) begin errors++; $display("[TB] FAIL midreset_stall: got %b want 1", Cache_Stall); end
    finishCycle();
    Reset = 1'b0;
    modelFlush();
    fetch(32'h0, 0, -1, 1'b0, s);
    checks++;
    if (s != 5) begin errors++; $display("[TB] FAIL midreset_refetch_stalls: got %0d want 5", s); end
  endtask

  task automatic test_random();
    int s, waits, fc;
    logic [31:0] pc;
    for (int n = 0; n < 60; n++) begin
      pc = (32'($urandom_range(0, 2)) << (O + I + 2)) | (32'($urandom_range(0, 3)) << (O + 2))
         | (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
      waits = $urandom_range(0, 2);
      fc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, WORDS * (waits + 1)) : -1;
      fetch(pc, waits, fc, 1'($urandom), s);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_wait_states();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
